// File: rtl/spi_master_ctrl_if.sv
// ---------------------------------------------------------------------------
// spi_master_ctrl_if : word handshake and SPI pin bundle for spi_master_ctrl
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface spi_master_ctrl_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              sclk;
  logic              ss;
  logic              mosi;
  logic              miso;

  modport master (
    input  tx_data, tx_valid, miso,
    output tx_ready, rx_data, rx_valid, sclk, ss, mosi
  );

  modport slave (
    output tx_data, tx_valid, miso,
    input  tx_ready, rx_data, rx_valid, sclk, ss, mosi
  );
endinterface

`default_nettype wire

// File: rtl/spi_master_ctrl.sv
// ---------------------------------------------------------------------------
// spi_master_ctrl : mode-0 SPI master, MSB first, burst when words arrive in GAP
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module spi_master_ctrl #(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 2
) (
  input  wire logic           clk,
  input  wire logic           rst,
  spi_master_ctrl_if.master   bus
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [DIV_W-1:0] c_div_last  = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] c_bits_last = CNT_W'(DATA_W);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEAD  = 3'd1,
    S_XFER  = 3'd2,
    S_GAP   = 3'd3,
    S_TRAIL = 3'd4
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [DIV_W-1:0]    r_div, w_div_nxt;
  logic [CNT_W-1:0]    r_bits, w_bits_nxt;
  logic [DATA_W-1:0]   r_tx_sh, w_tx_sh_nxt;
  logic [DATA_W-1:0]   r_rx_sh, w_rx_sh_nxt;
  logic [DATA_W-1:0]   r_rx_data, w_rx_data_nxt;
  logic                r_rx_valid, w_rx_valid_nxt;
  logic                r_sclk, w_sclk_nxt;
  logic                r_ss, w_ss_nxt;
  logic                r_mosi, w_mosi_nxt;

  logic                w_tx_ready;
  logic                w_accept;
  logic                w_div_end;

  assign w_tx_ready = (r_state == S_IDLE) || (r_state == S_GAP);
  assign w_accept   = bus.tx_valid && w_tx_ready;
  assign w_div_end  = (r_div == c_div_last);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_div      <= '0;
      r_bits     <= '0;
      r_tx_sh    <= '0;
      r_rx_sh    <= '0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_sclk     <= 1'b0;
      r_ss       <= 1'b1;
      r_mosi     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_div      <= w_div_nxt;
      r_bits     <= w_bits_nxt;
      r_tx_sh    <= w_tx_sh_nxt;
      r_rx_sh    <= w_rx_sh_nxt;
      r_rx_data  <= w_rx_data_nxt;
      r_rx_valid <= w_rx_valid_nxt;
      r_sclk     <= w_sclk_nxt;
      r_ss       <= w_ss_nxt;
      r_mosi     <= w_mosi_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_div_nxt      = r_div;
    w_bits_nxt     = r_bits;
    w_tx_sh_nxt    = r_tx_sh;
    w_rx_sh_nxt    = r_rx_sh;
    w_rx_data_nxt  = r_rx_data;
    w_rx_valid_nxt = 1'b0;
    w_sclk_nxt     = r_sclk;
    w_ss_nxt       = r_ss;
    w_mosi_nxt     = r_mosi;

    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_ss_nxt    = 1'b0;
          w_mosi_nxt  = bus.tx_data[DATA_W-1];
          w_tx_sh_nxt = {bus.tx_data[DATA_W-2:0], 1'b0};
          w_div_nxt   = '0;
          w_state_nxt = S_LEAD;
        end
      end
      S_LEAD: begin
        // End of ss-to-sclk setup doubles as the first rising edge.
        if (w_div_end) begin
          w_div_nxt   = '0;
          w_sclk_nxt  = 1'b1;
          w_rx_sh_nxt = {r_rx_sh[DATA_W-2:0], bus.miso};
          w_bits_nxt  = r_bits + 1'b1;
          w_state_nxt = S_XFER;
        end else begin
          w_div_nxt = r_div + 1'b1;
        end
      end
      S_XFER: begin
        if (w_div_end) begin
          w_div_nxt  = '0;
          w_sclk_nxt = ~r_sclk;
          if (!r_sclk) begin
            w_rx_sh_nxt = {r_rx_sh[DATA_W-2:0], bus.miso};
            w_bits_nxt  = r_bits + 1'b1;
          end else if (r_bits == c_bits_last) begin
            w_rx_data_nxt  = r_rx_sh;
            w_rx_valid_nxt = 1'b1;
            w_bits_nxt     = '0;
            w_state_nxt    = S_GAP;
          end else begin
            w_mosi_nxt  = r_tx_sh[DATA_W-1];
            w_tx_sh_nxt = {r_tx_sh[DATA_W-2:0], 1'b0};
          end
        end else begin
          w_div_nxt = r_div + 1'b1;
        end
      end
      S_GAP: begin
        // A word accepted here continues the burst with ss kept low.
        if (w_accept) begin
          w_mosi_nxt  = bus.tx_data[DATA_W-1];
          w_tx_sh_nxt = {bus.tx_data[DATA_W-2:0], 1'b0};
          w_div_nxt   = '0;
          w_state_nxt = S_XFER;
        end else if (w_div_end) begin
          w_ss_nxt    = 1'b1;
          w_div_nxt   = '0;
          w_state_nxt = S_TRAIL;
        end else begin
          w_div_nxt = r_div + 1'b1;
        end
      end
      S_TRAIL: begin
        if (w_div_end) begin
          w_div_nxt   = '0;
          w_state_nxt = S_IDLE;
        end else begin
          w_div_nxt = r_div + 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign bus.tx_ready = w_tx_ready;
  assign bus.rx_data  = r_rx_data;
  assign bus.rx_valid = r_rx_valid;
  assign bus.sclk     = r_sclk;
  assign bus.ss       = r_ss;
  assign bus.mosi     = r_mosi;

endmodule

`default_nettype wire
